// File: rtl/lane_dly_seq_if.sv
// Request/completion and delay-line bus for lane_dly_seq.
// The slave modport is the sequencer; the master modport is the requester
// together with the lane controllers that report out-of-range.
interface lane_dly_seq_if #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8,
    parameter int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
    logic                         REQ_VALID;
    logic                         REQ_READY;
    logic                         REQ_OP;
    logic [LW-1:0]                REQ_LANE;
    logic                         REQ_DIR;
    logic [TAP_W-1:0]             REQ_TAPS;
    logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE;
    logic [NUM_LANES-1:0]         DELAY_LINE_SEL;
    logic [NUM_LANES-1:0]         DELAY_LINE_LOAD;
    logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION;
    logic [NUM_LANES-1:0]         DELAY_LINE_MOVE;
    logic                         HS_IO_CLK_PAUSE;
    logic                         DONE_VALID;
    logic [1:0]                   DONE_STATUS;
    logic [TAP_W-1:0]             DONE_TAPS;
    logic [NUM_LANES*TAP_W-1:0]   TAP_POS;

    modport master (
        output REQ_VALID, REQ_OP, REQ_LANE, REQ_DIR, REQ_TAPS,
               DELAY_LINE_OUT_OF_RANGE,
        input  REQ_READY, DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION,
               DELAY_LINE_MOVE, HS_IO_CLK_PAUSE, DONE_VALID, DONE_STATUS,
               DONE_TAPS, TAP_POS
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_LANE, REQ_DIR, REQ_TAPS,
               DELAY_LINE_OUT_OF_RANGE,
        output REQ_READY, DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION,
               DELAY_LINE_MOVE, HS_IO_CLK_PAUSE, DONE_VALID, DONE_STATUS,
               DONE_TAPS, TAP_POS
    );
endinterface

// File: rtl/lane_dly_seq.sv
// Delay-line lane sequencer: steps a lane's tap one pulse at a time (MOVE)
// or reloads it under a high-speed clock pause (LOAD), tracking each lane's
// tap position and reporting a completion status.
module lane_dly_seq #(
    parameter int NUM_LANES   = 4,
    parameter int TAP_W       = 8,
    parameter int MAX_TAPS    = 127,
    parameter int DEFAULT_TAP = 1,
    parameter int MOVE_GAP    = 3,
    parameter int PAUSE_CYC   = 2
) (
    input logic           FAB_CLK,
    input logic           RESET,
    lane_dly_seq_if.slave bus
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = 16;

    localparam logic [1:0] STAT_OK       = 2'b00;
    localparam logic [1:0] STAT_RANGE    = 2'b01;
    localparam logic [1:0] STAT_BAD_LANE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        MOVE,
        GAP,
        PAUSE,
        LOAD,
        HOLD,
        DONE
    } state_t;

    state_t                              state_q, state_d;
    logic [LW-1:0]                       lane_q, lane_d;
    logic                                dir_q, dir_d;
    logic [TAP_W-1:0]                    taps_left_q, taps_left_d;
    logic [TAP_W-1:0]                    moved_q, moved_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [1:0]                          status_q, status_d;
    logic [NUM_LANES-1:0][TAP_W-1:0]     tap_pos_q, tap_pos_d;

    logic                                ready_q, ready_d;
    logic [NUM_LANES-1:0]                sel_q, sel_d;
    logic [NUM_LANES-1:0]                load_q, load_d;
    logic [NUM_LANES-1:0]                dir_out_q, dir_out_d;
    logic [NUM_LANES-1:0]                move_q, move_d;
    logic                                pause_q, pause_d;
    logic                                done_valid_q, done_valid_d;
    logic [1:0]                          done_status_q, done_status_d;
    logic [TAP_W-1:0]                    done_taps_q, done_taps_d;

    logic [NUM_LANES-1:0]                lane_oh_q, lane_oh_d;
    logic [TAP_W-1:0]                    pos_cur;
    logic                                at_limit;
    logic                                oor;
    logic                                lane_bad;

    function automatic logic [NUM_LANES-1:0] onehot(input logic [LW-1:0] l);
        logic [NUM_LANES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            v[i] = (l == LW'(i));
        end
        return v;
    endfunction

    // Lane decode, current-lane position and range conditions of the captured request.
    always_comb begin
        lane_oh_q = onehot(lane_q);
        pos_cur   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_oh_q[i]) begin
                pos_cur = tap_pos_q[i];
            end
        end
        at_limit = dir_q ? (pos_cur == TAP_W'(MAX_TAPS)) : (pos_cur == '0);
        oor      = |(bus.DELAY_LINE_OUT_OF_RANGE & lane_oh_q);
        lane_bad = ({1'b0, bus.REQ_LANE} >= (LW+1)'(NUM_LANES));
    end

    // Next-state logic and per-pulse bookkeeping of the sequencer.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        dir_d       = dir_q;
        taps_left_d = taps_left_q;
        moved_d     = moved_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        tap_pos_d   = tap_pos_q;

        case (state_q)
            IDLE: begin
                if (bus.REQ_VALID) begin
                    lane_d      = bus.REQ_LANE;
                    dir_d       = bus.REQ_DIR;
                    taps_left_d = bus.REQ_TAPS;
                    moved_d     = '0;
                    status_d    = STAT_OK;
                    if (lane_bad) begin
                        status_d = STAT_BAD_LANE;
                        state_d  = DONE;
                    end else if (bus.REQ_OP) begin
                        cnt_d   = CW'(PAUSE_CYC - 1);
                        state_d = PAUSE;
                    end else begin
                        state_d = SEL;
                    end
                end
            end
            SEL: begin
                if (taps_left_q == '0) begin
                    state_d = DONE;
                end else if (at_limit) begin
                    status_d = STAT_RANGE;
                    state_d  = DONE;
                end else begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                cnt_d   = CW'(MOVE_GAP - 1);
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (oor) begin
                    status_d = STAT_RANGE;
                    state_d  = DONE;
                end else if (taps_left_q == '0) begin
                    state_d = DONE;
                end else if (at_limit) begin
                    status_d = STAT_RANGE;
                    state_d  = DONE;
                end else begin
                    state_d = MOVE;
                end
            end
            PAUSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = HOLD;
            end
            HOLD: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (lane_oh_q[i]) begin
                        tap_pos_d[i] = TAP_W'(DEFAULT_TAP);
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == MOVE) begin
            taps_left_d = taps_left_q - 1'b1;
            moved_d     = moved_q + 1'b1;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_oh_q[i]) begin
                    tap_pos_d[i] = dir_q ? (tap_pos_q[i] + 1'b1) : (tap_pos_q[i] - 1'b1);
                end
            end
        end
    end

    // Output decode from the next state so every output is a flop that matches the state it is in.
    always_comb begin
        lane_oh_d     = onehot(lane_d);
        ready_d       = 1'b0;
        sel_d         = '0;
        load_d        = '0;
        dir_out_d     = '0;
        move_d        = '0;
        pause_d       = 1'b0;
        done_valid_d  = 1'b0;
        done_status_d = done_status_q;
        done_taps_d   = done_taps_q;

        case (state_d)
            IDLE: begin
                ready_d = 1'b1;
            end
            SEL, GAP: begin
                sel_d     = lane_oh_d;
                dir_out_d = dir_d ? lane_oh_d : '0;
            end
            MOVE: begin
                sel_d     = lane_oh_d;
                dir_out_d = dir_d ? lane_oh_d : '0;
                move_d    = lane_oh_d;
            end
            PAUSE, HOLD: begin
                pause_d = 1'b1;
            end
            LOAD: begin
                pause_d = 1'b1;
                sel_d   = lane_oh_d;
                load_d  = lane_oh_d;
            end
            DONE: begin
                done_valid_d  = 1'b1;
                done_status_d = status_d;
                done_taps_d   = moved_d;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // State, working registers and registered outputs; reset abandons any sequence in flight.
    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            lane_q        <= '0;
            dir_q         <= 1'b0;
            taps_left_q   <= '0;
            moved_q       <= '0;
            cnt_q         <= '0;
            status_q      <= STAT_OK;
            for (int i = 0; i < NUM_LANES; i++) begin
                tap_pos_q[i] <= TAP_W'(DEFAULT_TAP);
            end
            ready_q       <= 1'b1;
            sel_q         <= '0;
            load_q        <= '0;
            dir_out_q     <= '0;
            move_q        <= '0;
            pause_q       <= 1'b0;
            done_valid_q  <= 1'b0;
            done_status_q <= STAT_OK;
            done_taps_q   <= '0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            dir_q         <= dir_d;
            taps_left_q   <= taps_left_d;
            moved_q       <= moved_d;
            cnt_q         <= cnt_d;
            status_q      <= status_d;
            tap_pos_q     <= tap_pos_d;
            ready_q       <= ready_d;
            sel_q         <= sel_d;
            load_q        <= load_d;
            dir_out_q     <= dir_out_d;
            move_q        <= move_d;
            pause_q       <= pause_d;
            done_valid_q  <= done_valid_d;
            done_status_q <= done_status_d;
            done_taps_q   <= done_taps_d;
        end
    end

    assign bus.REQ_READY            = ready_q;
    assign bus.DELAY_LINE_SEL       = sel_q;
    assign bus.DELAY_LINE_LOAD      = load_q;
    assign bus.DELAY_LINE_DIRECTION = dir_out_q;
    assign bus.DELAY_LINE_MOVE      = move_q;
    assign bus.HS_IO_CLK_PAUSE      = pause_q;
    assign bus.DONE_VALID           = done_valid_q;
    assign bus.DONE_STATUS          = done_status_q;
    assign bus.DONE_TAPS            = done_taps_q;
    assign bus.TAP_POS              = tap_pos_q;
endmodule

// File: tb/tb_lane_dly_seq.sv
// Self-checking bench for lane_dly_seq: directed scenarios plus random
// MOVE/LOAD traffic compared against a sequence-level reference model.
module tb_lane_dly_seq;
    localparam int NL   = 4;
    localparam int TW   = 8;
    localparam int MAXT = 12;
    localparam int DEF  = 1;
    localparam int GAPC = 3;
    localparam int PC   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;
    int model_pos [NL];

    always #5 clk = ~clk;

    lane_dly_seq_if #(.NUM_LANES(NL), .TAP_W(TW)) bus ();
    lane_dly_seq_if #(.NUM_LANES(3), .TAP_W(TW)) busB ();

    lane_dly_seq #(
        .NUM_LANES(NL), .TAP_W(TW), .MAX_TAPS(MAXT),
        .DEFAULT_TAP(DEF), .MOVE_GAP(GAPC), .PAUSE_CYC(PC)
    ) dut (
        .FAB_CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    lane_dly_seq #(
        .NUM_LANES(3), .TAP_W(TW), .MAX_TAPS(MAXT),
        .DEFAULT_TAP(DEF), .MOVE_GAP(GAPC), .PAUSE_CYC(PC)
    ) dutB (
        .FAB_CLK(clk),
        .RESET(rst),
        .bus(busB)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkPositions(input string tag);
        for (int i = 0; i < NL; i++) begin
            checkOutput($sformatf("%s_pos%0d", tag, i), int'(bus.TAP_POS[i*TW +: TW]), model_pos[i]);
        end
    endtask

    // Issues one request, holds REQ_VALID with scrambled fields while busy,
    // and compares the whole sequence against the reference model.
    task automatic applyStimulus(input bit op, input int lane, input bit dir,
                                 input int taps, input int kstop);
        int expPulse [$];
        int expOff, expStatus, moved, pos;
        int pulses, badTiming, stray, seqErr, readyHi, doneOff;
        bit expSel, expDir, expLoad, expPause;
        logic [NL-1:0] oorv;

        expStatus = 0;
        moved     = 0;
        pos       = model_pos[lane];
        if (op) begin
            expOff = PC + 3;
            pos    = DEF;
        end else begin
            for (int k = 1; k <= taps; k++) begin
                if ((dir && pos == MAXT) || (!dir && pos == 0)) begin
                    expStatus = 1;
                    break;
                end
                expPulse.push_back(2 + (k - 1) * (GAPC + 1));
                pos   = dir ? pos + 1 : pos - 1;
                moved = moved + 1;
                if (k == kstop) begin
                    expStatus = 1;
                    break;
                end
            end
            expOff = 2 + moved * (GAPC + 1);
        end
        model_pos[lane] = pos;

        @(negedge clk);
        checkOutput("ready_idle", int'(bus.REQ_READY), 1);
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP    = op;
        bus.REQ_LANE  = 2'(lane);
        bus.REQ_DIR   = dir;
        bus.REQ_TAPS  = 8'(taps);
        bus.DELAY_LINE_OUT_OF_RANGE = '0;

        pulses = 0; badTiming = 0; stray = 0; seqErr = 0; readyHi = 0; doneOff = -1;
        for (int off = 1; off <= 200; off++) begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                if (i != lane && (bus.DELAY_LINE_SEL[i] || bus.DELAY_LINE_LOAD[i] ||
                                  bus.DELAY_LINE_MOVE[i] || bus.DELAY_LINE_DIRECTION[i]))
                    stray++;
            end
            if (bus.DELAY_LINE_MOVE[lane]) begin
                if (pulses >= expPulse.size() || expPulse[pulses] != off) badTiming++;
                pulses++;
            end
            if (op) begin
                expSel   = (off == PC + 1);
                expLoad  = expSel;
                expDir   = 1'b0;
                expPause = (off < expOff);
            end else begin
                expSel   = (off < expOff);
                expLoad  = 1'b0;
                expDir   = expSel && dir;
                expPause = 1'b0;
            end
            if (bus.DELAY_LINE_SEL[lane] !== expSel || bus.DELAY_LINE_LOAD[lane] !== expLoad ||
                bus.DELAY_LINE_DIRECTION[lane] !== expDir || bus.HS_IO_CLK_PAUSE !== expPause)
                seqErr++;
            if (bus.REQ_READY) readyHi++;
            if (bus.DONE_VALID) begin
                doneOff = off;
                break;
            end
            oorv       = NL'($urandom);
            oorv[lane] = (kstop != 0) && (pulses >= kstop);
            bus.DELAY_LINE_OUT_OF_RANGE = oorv;
            bus.REQ_OP   = 1'($urandom_range(0, 1));
            bus.REQ_LANE = 2'($urandom_range(0, 3));
            bus.REQ_DIR  = 1'($urandom_range(0, 1));
            bus.REQ_TAPS = 8'($urandom_range(0, 255));
        end
        bus.REQ_VALID = 1'b0;
        bus.DELAY_LINE_OUT_OF_RANGE = '0;

        checkOutput("done_cycle", doneOff, expOff);
        checkOutput("done_status", int'(bus.DONE_STATUS), expStatus);
        checkOutput("done_taps", int'(bus.DONE_TAPS), moved);
        checkOutput("pulse_count", pulses, expPulse.size());
        checkOutput("pulse_timing_errs", badTiming, 0);
        checkOutput("stray_lane_strobes", stray, 0);
        checkOutput("seq_strobe_errs", seqErr, 0);
        checkOutput("ready_while_busy", readyHi, 0);
        checkPositions("after_op");

        @(negedge clk);
        checkOutput("status_hold", int'(bus.DONE_STATUS), expStatus);
        checkOutput("taps_hold", int'(bus.DONE_TAPS), moved);
        checkOutput("done_one_cycle", int'(bus.DONE_VALID), 0);
    endtask

    initial begin
        int dv;
        bit rop, rdir;
        int rlane, rtaps, rk;

        bus.REQ_VALID = 1'b0; bus.REQ_OP = 1'b0; bus.REQ_LANE = '0;
        bus.REQ_DIR = 1'b0; bus.REQ_TAPS = '0; bus.DELAY_LINE_OUT_OF_RANGE = '0;
        busB.REQ_VALID = 1'b0; busB.REQ_OP = 1'b0; busB.REQ_LANE = '0;
        busB.REQ_DIR = 1'b0; busB.REQ_TAPS = '0; busB.DELAY_LINE_OUT_OF_RANGE = '0;
        for (int i = 0; i < NL; i++) model_pos[i] = DEF;

        repeat (3) @(negedge clk);
        checkOutput("reset_strobes", int'({bus.DELAY_LINE_SEL, bus.DELAY_LINE_LOAD,
                    bus.DELAY_LINE_MOVE, bus.DELAY_LINE_DIRECTION}), 0);
        checkOutput("reset_pause_done", int'({bus.HS_IO_CLK_PAUSE, bus.DONE_VALID}), 0);
        checkOutput("reset_status", int'(bus.DONE_STATUS), 0);
        checkOutput("reset_taps", int'(bus.DONE_TAPS), 0);
        checkPositions("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", int'(bus.REQ_READY), 1);

        $display("[TB] directed scenarios");
        applyStimulus(1'b0, 2, 1'b1, 3, 0);
        applyStimulus(1'b0, 0, 1'b0, 5, 0);
        applyStimulus(1'b0, 1, 1'b1, 6, 2);
        applyStimulus(1'b1, 3, 1'b0, 0, 0);
        applyStimulus(1'b0, 2, 1'b1, 12, 0);
        applyStimulus(1'b0, 3, 1'b0, 0, 0);

        $display("[TB] reset during move");
        @(negedge clk);
        bus.REQ_VALID = 1'b1; bus.REQ_OP = 1'b0; bus.REQ_LANE = 2'd1;
        bus.REQ_DIR = 1'b1; bus.REQ_TAPS = 8'd4;
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("gap_sel_before_reset", int'(bus.DELAY_LINE_SEL), 2);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_strobes", int'({bus.DELAY_LINE_SEL, bus.DELAY_LINE_LOAD,
                    bus.DELAY_LINE_MOVE, bus.DELAY_LINE_DIRECTION, bus.HS_IO_CLK_PAUSE}), 0);
        dv = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.DONE_VALID) dv++;
        end
        rst = 1'b0;
        for (int i = 0; i < NL; i++) model_pos[i] = DEF;
        repeat (2) begin
            @(negedge clk);
            if (bus.DONE_VALID) dv++;
        end
        checkOutput("no_done_after_abort", dv, 0);
        checkOutput("ready_after_abort", int'(bus.REQ_READY), 1);
        checkOutput("status_after_abort", int'(bus.DONE_STATUS), 0);
        checkPositions("abort");

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            rop   = ($urandom_range(0, 4) == 0);
            rlane = $urandom_range(0, NL - 1);
            rdir  = 1'($urandom_range(0, 1));
            rtaps = $urandom_range(0, 9);
            rk    = ($urandom_range(0, 3) == 0 && rtaps > 0) ? $urandom_range(1, rtaps) : 0;
            applyStimulus(rop, rlane, rdir, rtaps, rk);
        end

        $display("[TB] out-of-range lane on three-lane instance");
        @(negedge clk);
        busB.REQ_VALID = 1'b1; busB.REQ_OP = 1'b0; busB.REQ_LANE = 2'd3;
        busB.REQ_DIR = 1'b1; busB.REQ_TAPS = 8'd5;
        dv = -1;
        rk = 0;
        for (int off = 1; off <= 4; off++) begin
            @(negedge clk);
            busB.REQ_VALID = 1'b0;
            if (busB.DELAY_LINE_SEL != 0 || busB.DELAY_LINE_LOAD != 0 ||
                busB.DELAY_LINE_MOVE != 0 || busB.HS_IO_CLK_PAUSE) rk++;
            if (busB.DONE_VALID && dv < 0) begin
                dv = off;
                checkOutput("bad_lane_status", int'(busB.DONE_STATUS), 2);
                checkOutput("bad_lane_taps", int'(busB.DONE_TAPS), 0);
            end
        end
        checkOutput("bad_lane_done_cycle", dv, 1);
        checkOutput("bad_lane_strobes", rk, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bad_lane_pos%0d", i), int'(busB.TAP_POS[i*TW +: TW]), DEF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
